// File: rtl/onehot_decoder_pipe_pkg.sv
// ============================================================================
// Module : decoder_pkg
// Brief  : Shared decode-mode enum and width-legality helpers for index decoders.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'd0,
        MODE_THERM  = 2'd1,
        MODE_ACCUM  = 2'd2,
        MODE_SETCLR = 2'd3
    } dec_mode_e;

    localparam int c_MIN_IN_W  = 1;
    localparam int c_MAX_IN_W  = 8;
    localparam int c_MIN_OUT_W = 2;

    function automatic bit widths_legal(input int in_w, input int out_w);
        return (in_w >= c_MIN_IN_W) && (in_w <= c_MAX_IN_W) &&
               (out_w >= c_MIN_OUT_W) && (out_w <= (1 << in_w));
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_decoder_pipe_if.sv
// ============================================================================
// Module : onehot_decoder_pipe_if
// Brief  : Code input handshake, result output handshake and mask/status bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface onehot_decoder_pipe_if #(
    parameter int IN_W      = 5,
    parameter int OUT_W     = 2 ** IN_W,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_W-1:0]      in_code;
    logic [1:0]           in_mode;
    logic                 mask_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_vec;
    logic                 out_err;
    logic [OUT_W-1:0]     acc_mask;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_code, in_mode, mask_clr, out_ready,
        input  in_ready, out_valid, out_vec, out_err, acc_mask, err_cnt
    );

    modport slave (
        input  in_valid, in_code, in_mode, mask_clr, out_ready,
        output in_ready, out_valid, out_vec, out_err, acc_mask, err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/onehot_decoder_pipe_dec_core.sv
// ============================================================================
// Module : dec_core
// Brief  : Combinational index decode: one-hot, thermometer and range flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dec_core #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 2 ** IN_W
) (
    input  wire logic [IN_W-1:0]  i_code,
    output logic      [OUT_W-1:0] o_onehot,
    output logic      [OUT_W-1:0] o_therm,
    output logic                  o_in_range
);
    assign o_in_range = (32'(i_code) < OUT_W);

    // Out-of-range codes yield all-zero vectors so callers need no extra masking.
    for (genvar g = 0; g < OUT_W; g++) begin : g_bits
        assign o_onehot[g] = o_in_range && (32'(i_code) == g);
        assign o_therm[g]  = o_in_range && (32'(i_code) >= g);
    end
endmodule

`default_nettype wire

// File: rtl/onehot_decoder_pipe.sv
// ============================================================================
// Module : onehot_decoder_pipe
// Brief  : Registered multi-mode index decoder with handshake, mask and error count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module onehot_decoder_pipe
    import decoder_pkg::*;
#(
    parameter int IN_W      = 5,
    parameter int OUT_W     = 2 ** IN_W,
    parameter int ERR_CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    onehot_decoder_pipe_if.slave  bus
);
    if (!widths_legal(IN_W, OUT_W)) begin : g_illegal_widths
        $fatal(1, "onehot_decoder_pipe: illegal IN_W/OUT_W combination");
    end

    logic [OUT_W-1:0]     w_onehot;
    logic [OUT_W-1:0]     w_therm;
    logic                 w_in_range;
    logic                 w_in_ready;
    logic                 w_acc;
    dec_mode_e            w_mode;
    logic [OUT_W-1:0]     w_mask_base;
    logic [OUT_W-1:0]     w_mask_next;
    logic [OUT_W-1:0]     w_vec_next;

    logic                 r_out_valid;
    logic [OUT_W-1:0]     r_out_vec;
    logic                 r_out_err;
    logic [OUT_W-1:0]     r_acc_mask;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    dec_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_dec_core (
        .i_code     (bus.in_code),
        .o_onehot   (w_onehot),
        .o_therm    (w_therm),
        .o_in_range (w_in_range)
    );

    // Ready is forced high during reset, but nothing is accepted until reset drops.
    assign w_in_ready = rst || !r_out_valid || bus.out_ready;
    assign w_acc      = bus.in_valid && w_in_ready && !rst;
    assign w_mode     = dec_mode_e'(bus.in_mode);

    always_comb begin
        w_mask_base = bus.mask_clr ? '0 : r_acc_mask;
        w_mask_next = w_mask_base;
        w_vec_next  = '0;
        if (w_in_range) begin
            case (w_mode)
                MODE_ONEHOT: w_vec_next = w_onehot;
                MODE_THERM:  w_vec_next = w_therm;
                MODE_ACCUM: begin
                    w_mask_next = w_mask_base | w_onehot;
                    w_vec_next  = w_mask_base | w_onehot;
                end
                MODE_SETCLR: begin
                    w_mask_next = w_onehot;
                    w_vec_next  = w_onehot;
                end
                default: w_vec_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_vec   <= w_vec_next;
            r_out_err   <= !w_in_range;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_mask <= '0;
        end else if (w_acc) begin
            r_acc_mask <= w_mask_next;
        end else if (bus.mask_clr) begin
            r_acc_mask <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_acc && !w_in_range && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_vec   = r_out_vec;
    assign bus.out_err   = r_out_err;
    assign bus.acc_mask  = r_acc_mask;
    assign bus.err_cnt   = r_err_cnt;
endmodule

`default_nettype wire

// File: tb/tb_onehot_decoder_pipe.sv
// ============================================================================
// Module : tb_onehot_decoder_pipe
// Brief  : Drives a 32-wide and a 24-wide decoder in lockstep against a scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_onehot_decoder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    onehot_decoder_pipe_if #(.IN_W(5), .OUT_W(32), .ERR_CNT_W(8)) ifa ();
    onehot_decoder_pipe_if #(.IN_W(5), .OUT_W(24), .ERR_CNT_W(2)) ifb ();

    onehot_decoder_pipe #(.IN_W(5), .OUT_W(32), .ERR_CNT_W(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    onehot_decoder_pipe #(.IN_W(5), .OUT_W(24), .ERR_CNT_W(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic [31:0] va;
        logic        ea;
        logic [31:0] vb;
        logic        eb;
    } exp_t;

    exp_t        sbq[$];
    exp_t        held;
    int          checks = 0;
    int          errors = 0;
    logic        m_ov = 1'b0;
    logic [31:0] m_mask_a = '0;
    logic [31:0] m_mask_b = '0;
    int          m_cnt_a = 0;
    int          m_cnt_b = 0;

    function automatic void model(input int w, input int cmax, input logic [4:0] code,
                                  input logic [1:0] mode, input logic clr, input logic acc,
                                  inout logic [31:0] mask, inout int cnt,
                                  output logic [31:0] vec, output logic err);
        logic [63:0] full, oh, th, base;
        logic        inr;
        full = (64'd1 << w) - 64'd1;
        inr  = int'(code) < w;
        oh   = 64'd1 << code;
        th   = (64'd1 << (int'(code) + 1)) - 64'd1;
        base = clr ? 64'd0 : {32'd0, mask};
        vec  = '0;
        err  = !inr;
        if (inr) begin
            case (mode)
                2'd0: vec = oh[31:0];
                2'd1: begin th = th & full; vec = th[31:0]; end
                2'd2: begin base = base | oh; vec = base[31:0]; end
                default: begin base = oh; vec = oh[31:0]; end
            endcase
        end
        if (acc) mask = base[31:0];
        else if (clr) mask = '0;
        if (acc && !inr && cnt < cmax) cnt = cnt + 1;
    endfunction

    task automatic drive(input logic v, input logic [4:0] code, input logic [1:0] mode,
                         input logic clr, input logic ordy);
        ifa.in_valid = v;    ifb.in_valid = v;
        ifa.in_code = code;  ifb.in_code = code;
        ifa.in_mode = mode;  ifb.in_mode = mode;
        ifa.mask_clr = clr;  ifb.mask_clr = clr;
        ifa.out_ready = ordy; ifb.out_ready = ordy;
    endtask

    // One clock: drive at negedge, predict, then compare just after the rising edge.
    task automatic cycle(input logic v, input logic [4:0] code, input logic [1:0] mode,
                         input logic clr, input logic ordy);
        logic exp_rdy, acc;
        exp_t e, got;
        drive(v, code, mode, clr, ordy);
        #1;
        exp_rdy = !m_ov || ordy;
        checks++;
        if (ifa.in_ready !== exp_rdy || ifb.in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready: got a=%b b=%b expected %b", ifa.in_ready, ifb.in_ready, exp_rdy);
        end
        acc = v && exp_rdy;
        model(32, 255, code, mode, clr, acc, m_mask_a, m_cnt_a, e.va, e.ea);
        model(24, 3, code, mode, clr, acc, m_mask_b, m_cnt_b, e.vb, e.eb);
        if (acc) sbq.push_back(e);
        if (acc) m_ov = 1'b1;
        else if (ordy) m_ov = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ifa.out_valid !== m_ov || ifb.out_valid !== m_ov) begin
            errors++;
            $display("FAIL out_valid: got a=%b b=%b expected %b", ifa.out_valid, ifb.out_valid, m_ov);
        end
        if (acc) begin
            got = sbq.pop_front();
            held = got;
        end
        if (m_ov) begin
            checks++;
            if (ifa.out_vec !== held.va || ifa.out_err !== held.ea) begin
                errors++;
                $display("FAIL result_a code=%0d: got vec=%h err=%b expected vec=%h err=%b",
                         code, ifa.out_vec, ifa.out_err, held.va, held.ea);
            end
            checks++;
            if (ifb.out_vec !== held.vb[23:0] || ifb.out_err !== held.eb) begin
                errors++;
                $display("FAIL result_b code=%0d: got vec=%h err=%b expected vec=%h err=%b",
                         code, ifb.out_vec, ifb.out_err, held.vb[23:0], held.eb);
            end
        end
        checks++;
        if (ifa.acc_mask !== m_mask_a || ifb.acc_mask !== m_mask_b[23:0]) begin
            errors++;
            $display("FAIL acc_mask: got a=%h b=%h expected a=%h b=%h",
                     ifa.acc_mask, ifb.acc_mask, m_mask_a, m_mask_b[23:0]);
        end
        checks++;
        if (int'(ifa.err_cnt) != m_cnt_a || int'(ifb.err_cnt) != m_cnt_b) begin
            errors++;
            $display("FAIL err_cnt: got a=%0d b=%0d expected a=%0d b=%0d",
                     ifa.err_cnt, ifb.err_cnt, m_cnt_a, m_cnt_b);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic offer, input logic ordy);
        rst = 1'b1;
        drive(offer, 5'd2, 2'd0, 1'b0, ordy);
        #1;
        checks++;
        if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got a=%b b=%b expected 1", ifa.in_ready, ifb.in_ready);
        end
        @(posedge clk);
        #1;
        m_ov = 1'b0; m_mask_a = '0; m_mask_b = '0; m_cnt_a = 0; m_cnt_b = 0;
        sbq.delete();
        checks++;
        if (ifa.out_valid !== 1'b0 || ifa.out_vec !== 32'd0 || ifa.out_err !== 1'b0 ||
            ifa.acc_mask !== 32'd0 || ifa.err_cnt !== 8'd0 ||
            ifb.out_valid !== 1'b0 || ifb.out_vec !== 24'd0 || ifb.out_err !== 1'b0 ||
            ifb.acc_mask !== 24'd0 || ifb.err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got a ov=%b vec=%h err=%b mask=%h cnt=%0d b ov=%b vec=%h mask=%h cnt=%0d expected all zero",
                     ifa.out_valid, ifa.out_vec, ifa.out_err, ifa.acc_mask, ifa.err_cnt,
                     ifb.out_valid, ifb.out_vec, ifb.acc_mask, ifb.err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b1);
        cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic test_onehot_sweep();
        do_reset(1'b0, 1'b1);
        for (int k = 0; k < 32; k++) begin
            cycle(1'b1, 5'(k), 2'd0, 1'b0, 1'b1);
            checks++;
            if (ifa.out_vec !== (32'd1 << k) || ifa.out_err !== 1'b0) begin
                errors++;
                $display("FAIL onehot_sweep k=%0d: got %h err=%b expected %h err=0",
                         k, ifa.out_vec, ifa.out_err, 32'd1 << k);
            end
        end
        cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic test_therm();
        do_reset(1'b0, 1'b1);
        cycle(1'b1, 5'd0, 2'd1, 1'b0, 1'b1);
        checks++;
        if (ifb.out_vec !== 24'h000001) begin
            errors++;
            $display("FAIL therm_k0: got %h expected 000001", ifb.out_vec);
        end
        cycle(1'b1, 5'd23, 2'd1, 1'b0, 1'b1);
        checks++;
        if (ifb.out_vec !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL therm_k23: got %h expected ffffff", ifb.out_vec);
        end
        cycle(1'b1, 5'd30, 2'd1, 1'b0, 1'b1);
        checks++;
        if (ifb.out_vec !== 24'h0 || ifb.out_err !== 1'b1 || ifb.err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL therm_k30: got vec=%h err=%b cnt=%0d expected vec=0 err=1 cnt=1",
                     ifb.out_vec, ifb.out_err, ifb.err_cnt);
        end
        cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic test_accum();
        logic [4:0]  codes[5] = '{5'd3, 5'd7, 5'd3, 5'd1, 5'd4};
        logic [1:0]  modes[5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
        logic        clrs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] want[5]  = '{32'h8, 32'h88, 32'h88, 32'h2, 32'h10};
        do_reset(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, codes[i], modes[i], clrs[i], 1'b1);
            checks++;
            if (ifa.out_vec !== want[i]) begin
                errors++;
                $display("FAIL accum step %0d: got %h expected %h", i, ifa.out_vec, want[i]);
            end
        end
        cycle(1'b0, 5'd0, 2'd0, 1'b1, 1'b1);
        checks++;
        if (ifa.acc_mask !== 32'd0) begin
            errors++;
            $display("FAIL mask_clr_idle: got %h expected 0", ifa.acc_mask);
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0, 1'b1);
        cycle(1'b1, 5'd5, 2'd2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'd9, 2'd2, 1'b0, 1'b0);
            checks++;
            if (ifa.out_vec !== 32'h20 || ifa.acc_mask !== 32'h20 || ifa.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall %0d: got vec=%h mask=%h rdy=%b expected vec=20 mask=20 rdy=0",
                         i, ifa.out_vec, ifa.acc_mask, ifa.in_ready);
            end
        end
        cycle(1'b1, 5'd9, 2'd2, 1'b0, 1'b1);
        checks++;
        if (ifa.out_vec !== 32'h220) begin
            errors++;
            $display("FAIL release: got %h expected 00000220", ifa.out_vec);
        end
        cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b1);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL backpressure_queue: got %0d pending expected 0", sbq.size());
        end
    endtask

    task automatic test_reset_midstream();
        do_reset(1'b0, 1'b1);
        for (int k = 4; k < 8; k++) cycle(1'b1, 5'(k), 2'd2, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        checks++;
        if (ifa.acc_mask !== 32'hF0 || ifa.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got mask=%h ov=%b expected mask=f0 ov=1", ifa.acc_mask, ifa.out_valid);
        end
        do_reset(1'b1, 1'b0);
        cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        do_reset(1'b0, 1'b1);
        for (int k = 24; k < 29; k++) cycle(1'b1, 5'(k), 2'd0, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 2'd0, 1'b0, 1'b1);
        checks++;
        if (ifb.err_cnt !== 2'd3 || ifa.err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL saturation: got b=%0d a=%0d expected b=3 a=0", ifb.err_cnt, ifa.err_cnt);
        end
    endtask

    initial begin
        drive(1'b0, 5'd0, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        test_reset();
        test_onehot_sweep();
        test_therm();
        test_accum();
        test_backpressure();
        test_reset_midstream();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
